// File: rtl/voice_synth_if.sv
// rtl/voice_synth_if.sv - sample strobe, voice tables and mixed-sample outputs of the voice bank
interface voice_synth_if #(
  parameter int NUM_VOICES = 8
);
  logic               sample_ce;
  logic               wave_sel;
  logic [31:0]        frequencies   [NUM_VOICES];
  logic [31:0]        voice_volumes [NUM_VOICES];
  logic signed [15:0] audio_out;
  logic               audio_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_ce, wave_sel, frequencies, voice_volumes,
    input  audio_out, audio_valid, busy, overrun
  );

  modport slave (
    input  sample_ce, wave_sel, frequencies, voice_volumes,
    output audio_out, audio_valid, busy, overrun
  );
endinterface

// File: rtl/voice_synth.sv
// rtl/voice_synth.sv - time-multiplexed phase-accumulator voice bank and mixer (option: VOICE_SYNTH_ENVELOPE_EN)
module voice_synth #(
  parameter int NUM_VOICES = 8,
  parameter int INC_MUL    = 5592,
  parameter int INC_SHIFT  = 16,
  parameter int ENV_STEP   = 256
) (
  input logic         clk,
  input logic         reset,
  voice_synth_if.slave bus
);
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SHIFT = $clog2(NUM_VOICES);
  // Sum of NUM_VOICES 16-bit terms needs SHIFT extra bits; dropping SHIFT LSBs yields 16 bits.
  localparam int ACC_W = 16 + SHIFT;
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  localparam logic [31:0] FULL_SCALE = 32'h0010_0000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [VW-1:0]           v;
  logic                    wave_lat;
  logic signed [ACC_W-1:0] acc;
  logic [31:0]             phase [NUM_VOICES];
  logic signed [15:0]      audio_out_r;
  logic                    audio_valid_r;
  logic                    overrun_r;

  logic [31:0]             cur_phase;
  logic [31:0]             cur_vol;
  logic [31:0]             inc;
  logic [20:0]             vol_clamped;
  logic [20:0]             gain;
  logic signed [15:0]      wave;
  logic signed [37:0]      wave_x;
  logic signed [37:0]      gain_x;
  logic signed [15:0]      term;
  logic signed [ACC_W-1:0] acc_next;

  assign cur_phase = phase[v];
  assign cur_vol   = bus.voice_volumes[v];

  // Per-voice datapath: clamp volume, pick waveform from the old phase, scale, accumulate.
  always_comb begin
    vol_clamped = '0;
    if (cur_vol[31]) begin
      vol_clamped = '0;
    end else if (cur_vol > FULL_SCALE) begin
      vol_clamped = FULL_SCALE[20:0];
    end else begin
      vol_clamped = cur_vol[20:0];
    end
    inc = 32'((64'(bus.frequencies[v]) * 64'(INC_MUL)) >> INC_SHIFT);
    if (wave_lat) begin
      wave = cur_phase[31] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      wave = $signed(cur_phase[31:16]);
    end
    wave_x   = 38'(wave);
    gain_x   = $signed({17'b0, gain});
    term     = 16'((wave_x * gain_x) >>> 20);
    acc_next = acc + {{SHIFT{term[15]}}, term};
  end

`ifdef VOICE_SYNTH_ENVELOPE_EN
  localparam logic [20:0] STEP = 21'(ENV_STEP);
  logic [20:0] env [NUM_VOICES];
  logic [20:0] env_cur;
  logic [20:0] env_next;

  assign env_cur = env[v];
  assign gain    = env_next;

  // Envelope slews toward the clamped volume by at most one step per visit.
  always_comb begin
    env_next = env_cur;
    if (vol_clamped > env_cur) begin
      env_next = ((vol_clamped - env_cur) <= STEP) ? vol_clamped : env_cur + STEP;
    end else begin
      env_next = ((env_cur - vol_clamped) <= STEP) ? vol_clamped : env_cur - STEP;
    end
  end

  // Envelope registers are updated on the same RUN visit that uses them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) env[i] <= '0;
    end else if (state == RUN) begin
      env[v] <= env_next;
    end
  end
`else
  assign gain = vol_clamped;
`endif

  // Sequencer: IDLE waits for a strobe, RUN walks the voices, DONE returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      v             <= '0;
      wave_lat      <= 1'b0;
      acc           <= '0;
      audio_out_r   <= '0;
      audio_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
    end else begin
      audio_valid_r <= 1'b0;
      if (bus.sample_ce && state != IDLE) overrun_r <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.sample_ce) begin
            wave_lat <= bus.wave_sel;
            acc      <= '0;
            v        <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          phase[v] <= cur_phase + inc;
          acc      <= acc_next;
          if (v == LAST) begin
            // Publish on the way into DONE so the pulse lands in the DONE cycle.
            audio_out_r   <= acc_next[ACC_W-1:SHIFT];
            audio_valid_r <= 1'b1;
            state         <= DONE;
          end else begin
            v <= v + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.audio_out   = audio_out_r;
  assign bus.audio_valid = audio_valid_r;
  assign bus.busy        = (state != IDLE);
  assign bus.overrun     = overrun_r;
endmodule

// File: tb/tb_voice_synth.sv
// tb/tb_voice_synth.sv - directed self-checking bench for voice_synth
module tb_voice_synth;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  voice_synth_if #(.NUM_VOICES(8)) bus ();

  voice_synth #(.NUM_VOICES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_voices();
    for (int i = 0; i < 8; i++) begin
      bus.frequencies[i]   = 32'd0;
      bus.voice_volumes[i] = 32'd0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Strobe one sample and wait (bounded) for audio_valid; lat counts cycles after the strobe.
  task automatic run_sample(output logic signed [15:0] out, output int lat);
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    lat = 1;
    while (bus.audio_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    out = bus.audio_out;
    tick();
  endtask

  task automatic test_reset();
    logic signed [15:0] s;
    int lat;
    int pulses;
    clear_voices();
    bus.wave_sel = 1'b0;
    bus.sample_ce = 1'b0;
    do_reset();
    tests_run++;
    if (bus.audio_out !== 16'sd0 || bus.audio_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: out=%0d valid=%b busy=%b overrun=%b, want 0/0/0/0",
               bus.audio_out, bus.audio_valid, bus.busy, bus.overrun);
    end
    bus.frequencies[0]   = 32'd440 << 20;
    bus.voice_volumes[0] = 32'h0010_0000;
    run_sample(s, lat);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("FAIL reset_latency: got %0d, want 9", lat);
    end
    run_sample(s, lat);
`ifndef VOICE_SYNTH_ENVELOPE_EN
    tests_run++;
    if (s !== 16'sd75) begin
      tests_failed++;
      $display("FAIL reset_pre_abort: got %0d, want 75", s);
    end
`endif
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.audio_out !== 16'sd0) begin
      tests_failed++;
      $display("FAIL reset_abort: busy=%b out=%0d, want 0/0", bus.busy, bus.audio_out);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.audio_valid === 1'b1) pulses++;
      tick();
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_valid: got %0d pulses, want 0", pulses);
    end
`ifndef VOICE_SYNTH_ENVELOPE_EN
    run_sample(s, lat);
    tests_run++;
    if (s !== 16'sd0) begin
      tests_failed++;
      $display("FAIL reset_phase_s1: got %0d, want 0", s);
    end
    run_sample(s, lat);
    tests_run++;
    if (s !== 16'sd75) begin
      tests_failed++;
      $display("FAIL reset_phase_s2: got %0d, want 75", s);
    end
`endif
  endtask

  task automatic test_saw();
    logic signed [15:0] s;
    int lat;
    logic signed [15:0] exp_s [3];
    exp_s[0] = 16'sd0;
    exp_s[1] = 16'sd75;
    exp_s[2] = 16'sd150;
    do_reset();
    clear_voices();
    bus.wave_sel = 1'b0;
    bus.frequencies[0]   = 32'd440 << 20;
    bus.voice_volumes[0] = 32'h0010_0000;
    for (int k = 0; k < 3; k++) begin
      run_sample(s, lat);
      tests_run++;
      if (s !== exp_s[k] || lat !== 9) begin
        tests_failed++;
        $display("FAIL saw_s%0d: got %0d lat %0d, want %0d lat 9", k + 1, s, lat, exp_s[k]);
      end
    end
    tick();
    tick();
    tests_run++;
    if (bus.audio_out !== 16'sd150) begin
      tests_failed++;
      $display("FAIL saw_hold: got %0d, want 150", bus.audio_out);
    end
  endtask

  task automatic test_wide_freq();
    logic signed [15:0] s;
    int lat;
    do_reset();
    clear_voices();
    bus.wave_sel = 1'b0;
    bus.frequencies[0]   = 32'hFFFF_FFFF;
    bus.voice_volumes[0] = 32'h0010_0000;
    for (int k = 1; k <= 7; k++) begin
      run_sample(s, lat);
      if (k == 2) begin
        tests_run++;
        if (s !== 16'sd698) begin
          tests_failed++;
          $display("FAIL wide_s2: got %0d, want 698", s);
        end
      end
      if (k == 7) begin
        tests_run++;
        if (s !== -16'sd3999) begin
          tests_failed++;
          $display("FAIL wide_neg_s7: got %0d, want -3999", s);
        end
      end
    end
  endtask

  task automatic test_square_full();
    logic signed [15:0] s;
    int lat;
    int busy_cycles;
    do_reset();
    clear_voices();
    bus.wave_sel = 1'b1;
    for (int i = 0; i < 8; i++) bus.voice_volumes[i] = 32'h0010_0000;
    run_sample(s, lat);
    tests_run++;
    if (s !== 16'sd32767 || lat !== 9) begin
      tests_failed++;
      $display("FAIL square_s1: got %0d lat %0d, want 32767 lat 9", s, lat);
    end
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    bus.wave_sel  = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      tick();
    end
    tests_run++;
    if (busy_cycles !== 9 || bus.audio_out !== 16'sd32767) begin
      tests_failed++;
      $display("FAIL square_s2_busy: busy %0d out %0d, want 9 / 32767", busy_cycles, bus.audio_out);
    end
  endtask

  task automatic test_volume_clamp();
    logic signed [15:0] s1;
    logic signed [15:0] s2;
    int lat;
    logic [31:0] vols [3];
    logic signed [15:0] exp2 [3];
    vols[0] = 32'hFFFF_FFFB;
    vols[1] = 32'h0020_0000;
    vols[2] = 32'h0008_0000;
    exp2[0] = 16'sd0;
    exp2[1] = 16'sd75;
    exp2[2] = 16'sd37;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      clear_voices();
      bus.wave_sel = 1'b0;
      bus.frequencies[0]   = 32'd440 << 20;
      bus.voice_volumes[0] = vols[k];
      run_sample(s1, lat);
      run_sample(s2, lat);
      tests_run++;
      if (s1 !== 16'sd0 || s2 !== exp2[k]) begin
        tests_failed++;
        $display("FAIL clamp_%0d: got %0d,%0d want 0,%0d", k, s1, s2, exp2[k]);
      end
    end
  endtask

  task automatic test_overrun();
    int pulses;
    int first_at;
    do_reset();
    clear_voices();
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    tick();
    tick();
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    pulses = 0;
    first_at = 0;
    for (int n = 4; n < 24; n++) begin
      if (bus.audio_valid === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = n;
      end
      tick();
    end
    tests_run++;
    if (pulses !== 1 || first_at !== 9) begin
      tests_failed++;
      $display("FAIL overrun_single: %0d pulses first at %0d, want 1 at 9", pulses, first_at);
    end
    tests_run++;
    if (bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: got %b, want 1", bus.overrun);
    end
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    tests_run++;
    if (bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_sticky: got %b, want 1", bus.overrun);
    end
  endtask

`ifdef VOICE_SYNTH_ENVELOPE_EN
  task automatic test_envelope();
    logic signed [15:0] s;
    int lat;
    do_reset();
    clear_voices();
    bus.wave_sel = 1'b1;
    bus.voice_volumes[0] = 32'h0010_0000;
    for (int k = 1; k <= 4097; k++) begin
      run_sample(s, lat);
      if (k == 1 || k == 2048 || k == 4096 || k == 4097) begin
        tests_run++;
        if (s !== ((k == 1) ? 16'sd0 : (k == 2048) ? 16'sd2047 : 16'sd4095)) begin
          tests_failed++;
          $display("FAIL env_s%0d: got %0d", k, s);
        end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.sample_ce = 1'b0;
    bus.wave_sel  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.frequencies[i]   = 32'd0;
      bus.voice_volumes[i] = 32'd0;
    end
    test_reset();
`ifdef VOICE_SYNTH_ENVELOPE_EN
    test_overrun();
    test_envelope();
`else
    test_saw();
    test_wide_freq();
    test_square_full();
    test_volume_clamp();
    test_overrun();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
